// File: rtl/decode_issue_queue_pkg.sv
// Shared decode definitions: RV32I base opcodes, RoB tag width and the
// control-field bundle produced by the per-instruction field decoder.
package decode_issue_queue_pkg;

  localparam int ROB_SIZE_WIDTH = 3;

  localparam logic [6:0] LUI     = 7'b0110111;
  localparam logic [6:0] AUIPC   = 7'b0010111;
  localparam logic [6:0] JAL     = 7'b1101111;
  localparam logic [6:0] JALR    = 7'b1100111;
  localparam logic [6:0] B_TYPE  = 7'b1100011;
  localparam logic [6:0] LD_TYPE = 7'b0000011;
  localparam logic [6:0] S_TYPE  = 7'b0100011;
  localparam logic [6:0] I_TYPE  = 7'b0010011;
  localparam logic [6:0] R_TYPE  = 7'b0110011;

  // Everything issue needs to know about an instruction except its immediate.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;       // zero when the instruction writes no register
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
    logic       has_rd;
    logic       to_rs;
    logic       to_lsb;
    logic       illegal;
  } dec_ctrl_t;

endpackage

// File: rtl/decode_issue_queue_instr_field_decode.sv
// Pure combinational field decoder: opcode -> immediate, register usage and
// target unit. Kept free of state so the Fetcher can reuse it for branch
// prediction.
module decode_issue_queue_instr_field_decode
  import decode_issue_queue_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o,
  output dec_ctrl_t   ctrl_o
);

  // Opcode-driven immediate selection and operand/destination usage.
  always_comb begin
    imm_o          = '0;
    ctrl_o         = '0;
    ctrl_o.opcode  = instr_i[6:0];
    ctrl_o.rs1     = instr_i[19:15];
    ctrl_o.rs2     = instr_i[24:20];
    case (instr_i[6:0])
      LUI, AUIPC: begin
        imm_o          = {instr_i[31:12], 12'b0};
        ctrl_o.has_rd  = 1'b1;
        ctrl_o.to_rs   = 1'b1;
      end
      JAL: begin
        imm_o          = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                          instr_i[20], instr_i[30:21], 1'b0};
        ctrl_o.has_rd  = 1'b1;
        ctrl_o.to_rs   = 1'b1;
      end
      JALR, I_TYPE: begin
        imm_o          = {{20{instr_i[31]}}, instr_i[31:20]};
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.has_rd  = 1'b1;
        ctrl_o.to_rs   = 1'b1;
      end
      LD_TYPE: begin
        imm_o          = {{20{instr_i[31]}}, instr_i[31:20]};
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.has_rd  = 1'b1;
        ctrl_o.to_lsb  = 1'b1;
      end
      B_TYPE: begin
        imm_o          = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                          instr_i[30:25], instr_i[11:8], 1'b0};
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.use_rs2 = 1'b1;
        ctrl_o.to_rs   = 1'b1;
      end
      S_TYPE: begin
        imm_o          = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.use_rs2 = 1'b1;
        ctrl_o.to_lsb  = 1'b1;
      end
      R_TYPE: begin
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.use_rs2 = 1'b1;
        ctrl_o.has_rd  = 1'b1;
        ctrl_o.to_rs   = 1'b1;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
    ctrl_o.rd = ctrl_o.has_rd ? instr_i[11:7] : 5'd0;
  end

endmodule

// File: rtl/decode_issue_queue.sv
// Instruction queue + registered issue stage between Fetcher and the
// RS/LSB/RoB/Reg cluster. Optional macro DECODE_ILLEGAL_TRAP_EN: unknown
// opcodes issue with illegal_out=1 (no unit target) instead of being dropped.
module decode_issue_queue
  import decode_issue_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int ROB_WIDTH   = ROB_SIZE_WIDTH,
  parameter int XLEN        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clear,
  input  logic                 fetch_valid,
  input  logic [XLEN-1:0]      fetch_instr,
  input  logic [XLEN-1:0]      fetch_addr,
  output logic                 fetch_ready,
  input  logic                 rob_full,
  input  logic                 rs_full,
  input  logic                 lsb_full,
  input  logic [ROB_WIDTH-1:0] rob_tail_id,
  output logic [4:0]           reg_id1,
  output logic [4:0]           reg_id2,
  input  logic [XLEN-1:0]      reg_value1_in,
  input  logic [XLEN-1:0]      reg_value2_in,
  input  logic                 has_dep1_in,
  input  logic                 has_dep2_in,
  input  logic [ROB_WIDTH-1:0] v_rob_id1_in,
  input  logic [ROB_WIDTH-1:0] v_rob_id2_in,
  output logic                 rename_valid,
  output logic [4:0]           rename_rd,
  output logic                 issue_valid,
  output logic                 issue_to_rs,
  output logic                 issue_to_lsb,
  output logic [XLEN-1:0]      instr_out,
  output logic [XLEN-1:0]      instr_addr_out,
  output logic [XLEN-1:0]      imm_out,
  output logic [6:0]           instr_type_out,
  output logic [4:0]           rd_out,
  output logic [XLEN-1:0]      reg_value1_out,
  output logic [XLEN-1:0]      reg_value2_out,
  output logic                 has_dep1_out,
  output logic                 has_dep2_out,
  output logic [ROB_WIDTH-1:0] v_rob_id1_out,
  output logic [ROB_WIDTH-1:0] v_rob_id2_out,
  output logic [ROB_WIDTH-1:0] rd_rob_id_out
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic                 illegal_out
`endif
);

  localparam int AW = $clog2(QUEUE_DEPTH);

  // Queue storage; head is read combinationally so Reg lookup overlaps decode.
  logic [XLEN-1:0] instr_mem [QUEUE_DEPTH];
  logic [XLEN-1:0] addr_mem  [QUEUE_DEPTH];
  // Pointers carry one wrap bit above the index to tell full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic            empty, full, push, pop, issue, can_go, unit_full;
  logic [XLEN-1:0] head_instr, head_addr, imm_ext;
  logic [31:0]     dec_imm;
  dec_ctrl_t       ctrl;
  logic            src1_en, src2_en;

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                       (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign fetch_ready = !full;
  assign push        = fetch_valid && !full && rdy && !clear;
  assign head_instr  = instr_mem[rd_ptr_q[AW-1:0]];
  assign head_addr   = addr_mem[rd_ptr_q[AW-1:0]];

  decode_issue_queue_instr_field_decode u_field_decode (
    .instr_i (head_instr[31:0]),
    .imm_o   (dec_imm),
    .ctrl_o  (ctrl)
  );

  assign imm_ext   = XLEN'($signed(dec_imm));
  assign can_go    = !empty && rdy && !clear;
  assign unit_full = (ctrl.to_rs && rs_full) || (ctrl.to_lsb && lsb_full);

`ifdef DECODE_ILLEGAL_TRAP_EN
  // Unknown opcodes still take a RoB slot so the trap is raised in order.
  assign issue = can_go && !rob_full && (ctrl.illegal || !unit_full);
  assign pop   = issue;
`else
  logic drop;
  // Unknown opcodes leave the queue quietly and never reach the RoB.
  assign drop  = can_go && ctrl.illegal;
  assign issue = can_go && !ctrl.illegal && !rob_full && !unit_full;
  assign pop   = issue || drop;
`endif

  assign reg_id1      = ctrl.rs1;
  assign reg_id2      = ctrl.rs2;
  assign rename_valid = issue && ctrl.has_rd && (ctrl.rd != 5'd0);
  assign rename_rd    = ctrl.rd;
  assign src1_en      = ctrl.use_rs1 && (ctrl.rs1 != 5'd0);
  assign src2_en      = ctrl.use_rs2 && (ctrl.rs2 != 5'd0);

  // Pointer update: flush empties the queue, otherwise advance on push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (rdy && clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Queue write port.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q[AW-1:0]] <= fetch_instr;
      addr_mem[wr_ptr_q[AW-1:0]]  <= fetch_addr;
    end
  end

  logic                 issue_valid_q, to_rs_q, to_lsb_q, dep1_q, dep2_q;
  logic [XLEN-1:0]      instr_q, addr_q, imm_q, val1_q, val2_q;
  logic [6:0]           opcode_q;
  logic [4:0]           rd_q;
  logic [ROB_WIDTH-1:0] tag1_q, tag2_q, own_tag_q;

  // Issue register: single-cycle pulse per fired instruction, held when !rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_q <= 1'b0;
      to_rs_q       <= 1'b0;
      to_lsb_q      <= 1'b0;
      instr_q       <= '0;
      addr_q        <= '0;
      imm_q         <= '0;
      opcode_q      <= '0;
      rd_q          <= '0;
      val1_q        <= '0;
      val2_q        <= '0;
      dep1_q        <= 1'b0;
      dep2_q        <= 1'b0;
      tag1_q        <= '0;
      tag2_q        <= '0;
      own_tag_q     <= '0;
    end else if (rdy) begin
      issue_valid_q <= issue;
      if (issue) begin
        to_rs_q   <= ctrl.to_rs;
        to_lsb_q  <= ctrl.to_lsb;
        instr_q   <= head_instr;
        addr_q    <= head_addr;
        imm_q     <= imm_ext;
        opcode_q  <= ctrl.opcode;
        rd_q      <= ctrl.rd;
        val1_q    <= src1_en ? reg_value1_in : '0;
        val2_q    <= src2_en ? reg_value2_in : '0;
        dep1_q    <= src1_en && has_dep1_in;
        dep2_q    <= src2_en && has_dep2_in;
        tag1_q    <= src1_en ? v_rob_id1_in : '0;
        tag2_q    <= src2_en ? v_rob_id2_in : '0;
        own_tag_q <= rob_tail_id;
      end
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q;
  // Illegal flag travels with the issued entry.
  always_ff @(posedge clk) begin
    if (rst)                illegal_q <= 1'b0;
    else if (rdy && issue)  illegal_q <= ctrl.illegal;
  end
  assign illegal_out = illegal_q;
`endif

  assign issue_valid    = issue_valid_q;
  assign issue_to_rs    = to_rs_q;
  assign issue_to_lsb   = to_lsb_q;
  assign instr_out      = instr_q;
  assign instr_addr_out = addr_q;
  assign imm_out        = imm_q;
  assign instr_type_out = opcode_q;
  assign rd_out         = rd_q;
  assign reg_value1_out = val1_q;
  assign reg_value2_out = val2_q;
  assign has_dep1_out   = dep1_q;
  assign has_dep2_out   = dep2_q;
  assign v_rob_id1_out  = tag1_q;
  assign v_rob_id2_out  = tag2_q;
  assign rd_rob_id_out  = own_tag_q;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue; builds with or without
// DECODE_ILLEGAL_TRAP_EN.
module tb_decode_issue_queue;

  logic        clk, rst, rdy, clear;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_instr, fetch_addr;
  logic        rob_full, rs_full, lsb_full;
  logic [2:0]  rob_tail_id;
  logic [4:0]  reg_id1, reg_id2;
  logic [31:0] reg_value1_in, reg_value2_in;
  logic        has_dep1_in, has_dep2_in;
  logic [2:0]  v_rob_id1_in, v_rob_id2_in;
  logic        rename_valid;
  logic [4:0]  rename_rd;
  logic        issue_valid, issue_to_rs, issue_to_lsb;
  logic [31:0] instr_out, instr_addr_out, imm_out;
  logic [6:0]  instr_type_out;
  logic [4:0]  rd_out;
  logic [31:0] reg_value1_out, reg_value2_out;
  logic        has_dep1_out, has_dep2_out;
  logic [2:0]  v_rob_id1_out, v_rob_id2_out, rd_rob_id_out;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        illegal_out;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  decode_issue_queue #(.QUEUE_DEPTH(4), .ROB_WIDTH(3), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rob_tail_id(rob_tail_id),
    .reg_id1(reg_id1), .reg_id2(reg_id2),
    .reg_value1_in(reg_value1_in), .reg_value2_in(reg_value2_in),
    .has_dep1_in(has_dep1_in), .has_dep2_in(has_dep2_in),
    .v_rob_id1_in(v_rob_id1_in), .v_rob_id2_in(v_rob_id2_in),
    .rename_valid(rename_valid), .rename_rd(rename_rd),
    .issue_valid(issue_valid), .issue_to_rs(issue_to_rs), .issue_to_lsb(issue_to_lsb),
    .instr_out(instr_out), .instr_addr_out(instr_addr_out), .imm_out(imm_out),
    .instr_type_out(instr_type_out), .rd_out(rd_out),
    .reg_value1_out(reg_value1_out), .reg_value2_out(reg_value2_out),
    .has_dep1_out(has_dep1_out), .has_dep2_out(has_dep2_out),
    .v_rob_id1_out(v_rob_id1_out), .v_rob_id2_out(v_rob_id2_out),
    .rd_rob_id_out(rd_rob_id_out)
`ifdef DECODE_ILLEGAL_TRAP_EN
    , .illegal_out(illegal_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_instr(input logic [31:0] instr, input logic [31:0] pc);
    fetch_valid = 1'b1;
    fetch_instr = instr;
    fetch_addr  = pc;
    $display("[TB] push pc=0x%08h instr=0x%08h", pc, instr);
    tick();
    fetch_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    fetch_valid = 1'b0; fetch_instr = '0; fetch_addr = '0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rob_tail_id = 3'd2;
    reg_value1_in = 32'h1234; reg_value2_in = 32'h5678;
    has_dep1_in = 1'b1; has_dep2_in = 1'b1;
    v_rob_id1_in = 3'd6; v_rob_id2_in = 3'd7;

    // Reset state
    tick(); tick();
    check("rst_issue_valid", issue_valid, 0);
    check("rst_instr_out", instr_out, 0);
    check("rst_rd_rob_id", rd_rob_id_out, 0);
    rst = 1'b0;
    tick();
    check("rst_fetch_ready", fetch_ready, 1);

    // ADDI x1,x0,5: rs1=x0 masks value/dep/tag, rs2 unused
    push_instr(32'h00500093, 32'h0);
    check("addi_rename_valid", rename_valid, 1);
    check("addi_rename_rd", rename_rd, 1);
    check("addi_reg_id1", reg_id1, 0);
    tick();
    $display("[TB] issue instr=0x%08h rd=%0d imm=0x%0h", instr_out, rd_out, imm_out);
    check("addi_issue_valid", issue_valid, 1);
    check("addi_to_rs", issue_to_rs, 1);
    check("addi_to_lsb", issue_to_lsb, 0);
    check("addi_imm", imm_out, 5);
    check("addi_rd", rd_out, 1);
    check("addi_dep1", has_dep1_out, 0);
    check("addi_val1", reg_value1_out, 0);
    check("addi_tag1", v_rob_id1_out, 0);
    check("addi_val2", reg_value2_out, 0);
    check("addi_own_tag", rd_rob_id_out, 2);
    check("addi_pc", instr_addr_out, 0);
    check("addi_type", instr_type_out, 7'h13);
    tick();
    check("addi_pulse_end", issue_valid, 0);

    // Fill four entries behind a full RS, then drain in order across the wrap
    rs_full = 1'b1;
    push_instr(32'h00100093, 32'h10);
    push_instr(32'h00200113, 32'h14);
    push_instr(32'h00300193, 32'h18);
    push_instr(32'h00400213, 32'h1C);
    check("fill_fetch_ready", fetch_ready, 0);
    check("fill_rename_blocked", rename_valid, 0);
    check("fill_no_issue", issue_valid, 0);
    rs_full = 1'b0;
    #1;
    check("drain_rename_valid", rename_valid, 1);
    check("drain_rename_rd", rename_rd, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      $display("[TB] issue instr=0x%08h rd=%0d imm=0x%0h", instr_out, rd_out, imm_out);
      check("drain_issue_valid", issue_valid, 1);
      check("drain_imm", imm_out, 64'(k));
      check("drain_rd", rd_out, 64'(k));
    end
    tick();
    check("drain_end", issue_valid, 0);
    check("drain_fetch_ready", fetch_ready, 1);

    // SW x2,8(x3) held off by a full LSB
    lsb_full = 1'b1;
    has_dep1_in = 1'b0; has_dep2_in = 1'b0;
    reg_value1_in = 32'h100; reg_value2_in = 32'hDEAD;
    push_instr(32'h0021A423, 32'h40);
    check("sw_reg_id1", reg_id1, 3);
    check("sw_reg_id2", reg_id2, 2);
    tick();
    check("sw_blocked1", issue_valid, 0);
    tick();
    check("sw_blocked2", issue_valid, 0);
    lsb_full = 1'b0;
    #1;
    check("sw_no_rename", rename_valid, 0);
    tick();
    $display("[TB] issue instr=0x%08h to_lsb=%0d imm=0x%0h", instr_out, issue_to_lsb, imm_out);
    check("sw_issue_valid", issue_valid, 1);
    check("sw_to_lsb", issue_to_lsb, 1);
    check("sw_to_rs", issue_to_rs, 0);
    check("sw_imm", imm_out, 8);
    check("sw_val1", reg_value1_out, 32'h100);
    check("sw_val2", reg_value2_out, 32'hDEAD);
    check("sw_rd", rd_out, 0);
    check("sw_pc", instr_addr_out, 32'h40);
    tick();

    // ADD x5,x6,x7 with rs2 pending in RoB entry 3
    rob_tail_id = 3'd5;
    has_dep2_in = 1'b1; v_rob_id2_in = 3'd3;
    has_dep1_in = 1'b0; v_rob_id1_in = 3'd0;
    push_instr(32'h007302B3, 32'h50);
    tick();
    $display("[TB] issue instr=0x%08h rd=%0d dep2=%0d", instr_out, rd_out, has_dep2_out);
    check("add_issue_valid", issue_valid, 1);
    check("add_dep2", has_dep2_out, 1);
    check("add_tag2", v_rob_id2_out, 3);
    check("add_dep1", has_dep1_out, 0);
    check("add_rd", rd_out, 5);
    check("add_own_tag", rd_rob_id_out, 5);

    // LUI x5,0x12345 ignores both sources
    has_dep1_in = 1'b1; v_rob_id1_in = 3'd4;
    push_instr(32'h123452B7, 32'h54);
    tick();
    $display("[TB] issue instr=0x%08h rd=%0d imm=0x%0h", instr_out, rd_out, imm_out);
    check("lui_issue_valid", issue_valid, 1);
    check("lui_dep1", has_dep1_out, 0);
    check("lui_dep2", has_dep2_out, 0);
    check("lui_tag1", v_rob_id1_out, 0);
    check("lui_tag2", v_rob_id2_out, 0);
    check("lui_imm", imm_out, 32'h12345000);
    check("lui_rd", rd_out, 5);
    tick();
    has_dep1_in = 1'b0; has_dep2_in = 1'b0;
    v_rob_id1_in = 3'd0; v_rob_id2_in = 3'd0;

    // Flush with three queued, one ready to fire and a push in the same cycle
    rs_full = 1'b1;
    push_instr(32'h00100093, 32'h60);
    push_instr(32'h00200113, 32'h64);
    push_instr(32'h00300193, 32'h68);
    clear = 1'b1; rs_full = 1'b0;
    fetch_valid = 1'b1; fetch_instr = 32'h00400213; fetch_addr = 32'h6C;
    #1;
    check("clr_rename_killed", rename_valid, 0);
    tick();
    clear = 1'b0; fetch_valid = 1'b0;
    check("clr_no_issue", issue_valid, 0);
    check("clr_fetch_ready", fetch_ready, 1);
    tick();
    check("clr_empty1", issue_valid, 0);
    tick();
    check("clr_empty2", issue_valid, 0);
    push_instr(32'h00600313, 32'h70);
    tick();
    check("clr_after_valid", issue_valid, 1);
    check("clr_after_imm", imm_out, 6);
    tick();

    // rdy low blocks push; issue_valid holds while rdy is low
    rdy = 1'b0;
    fetch_valid = 1'b1; fetch_instr = 32'h00700393; fetch_addr = 32'h80;
    tick();
    rdy = 1'b1; fetch_valid = 1'b0;
    tick();
    check("rdy_no_push1", issue_valid, 0);
    tick();
    check("rdy_no_push2", issue_valid, 0);
    push_instr(32'h00500093, 32'h84);
    rdy = 1'b0;
    tick();
    check("rdy_no_fire", issue_valid, 0);
    rdy = 1'b1;
    tick();
    check("rdy_fire", issue_valid, 1);
    rdy = 1'b0;
    tick();
    check("rdy_hold_valid", issue_valid, 1);
    rdy = 1'b1;
    tick();
    check("rdy_release", issue_valid, 0);

    // Unknown opcode 0x7F followed by ADDI x1,x0,9
    push_instr(32'h0000007F, 32'h90);
    check("ill_no_rename", rename_valid, 0);
    push_instr(32'h00900093, 32'h94);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check("ill_issue_valid", issue_valid, 1);
    check("ill_flag", illegal_out, 1);
    check("ill_to_rs", issue_to_rs, 0);
    check("ill_to_lsb", issue_to_lsb, 0);
    check("ill_pc", instr_addr_out, 32'h90);
    tick();
    check("ill_next_valid", issue_valid, 1);
    check("ill_next_flag", illegal_out, 0);
    check("ill_next_imm", imm_out, 9);
`else
    check("ill_dropped", issue_valid, 0);
    tick();
    check("ill_next_valid", issue_valid, 1);
    check("ill_next_imm", imm_out, 9);
    check("ill_next_pc", instr_addr_out, 32'h94);
`endif
    tick();
    check("ill_end", issue_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
